// File: rtl/psola_pkg.sv
// Shared constants, widths and playback state for the PSOLA output stage.
package psola_pkg;

  localparam int unsigned WINDOW_SIZE       = 2048;
  localparam int unsigned MAX_EXTENDED      = 2200;
  localparam int unsigned FRACTION_BITS     = 11;
  localparam int unsigned MAX_EXTENDED_BITS = $clog2(MAX_EXTENDED);
  localparam int unsigned LEN_BITS          = 12;
  localparam int unsigned ADDR_BITS         = MAX_EXTENDED_BITS + 1;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StPlayPend
  } play_state_e;

  function automatic logic [LEN_BITS-1:0] clip_len(input logic [LEN_BITS-1:0] len);
    if (len > LEN_BITS'(WINDOW_SIZE)) begin
      return LEN_BITS'(WINDOW_SIZE);
    end
    return len;
  endfunction

endpackage

// File: rtl/fx_to_pcm16.sv
// Registered round-half-up and saturate from signed fixed point to signed 16-bit PCM.
module fx_to_pcm16
  import psola_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [15:0] sample_o
);

  localparam logic signed [32:0] Half = 33'sd1 <<< (FRACTION_BITS - 1);

  logic signed [32:0] rounded;
  logic signed [32:0] shifted;
  logic [15:0]        sample_d;
  logic [15:0]        sample_q;

  always_comb begin
    // 33 bits so that adding the half LSB to 0x7FFFFFFF cannot wrap
    rounded = $signed({data_i[31], data_i}) + Half;
    shifted = rounded >>> FRACTION_BITS;
    if (shifted > 33'sd32767) begin
      sample_d = 16'h7fff;
    end else if (shifted < -33'sd32768) begin
      sample_d = 16'h8000;
    end else begin
      sample_d = shifted[15:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q <= '0;
    end else if (en_i) begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/psola_playback.sv
// Ping-pong buffer playback: reads one word per tick, zeroes it behind itself and emits PCM16.
module psola_playback
  import psola_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 sample_tick_in,
  input  logic [LEN_BITS-1:0]  window_len_in,
  input  logic                 window_len_valid_in,
  output logic [ADDR_BITS-1:0] buf_rd_addr_out,
  input  logic [31:0]          buf_rd_data_in,
  output logic [ADDR_BITS-1:0] buf_clr_addr_out,
  output logic                 buf_clr_we_out,
  output logic                 write_bank_out,
  output logic                 ready_out,
  output logic [15:0]          sample_out,
  output logic                 sample_valid_out,
  output logic                 underrun_out,
  output logic                 dropped_out
);

  play_state_e state_q, state_d, st_mid;
  logic play_bank_q, play_bank_d;
  logic write_bank_q, write_bank_d, wb_mid;
  logic [LEN_BITS-1:0] play_len_q, play_len_d;
  logic [LEN_BITS-1:0] pend_len_q, pend_len_d;
  logic [LEN_BITS-1:0] idx_q, idx_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic underrun_q, underrun_d;
  logic dropped_q, dropped_d;
  logic [2:0] pipe_vld_q;
  logic [2:0] pipe_rd_q;
  logic sample_valid_q;

  logic tick_ok;
  logic has_data;
  logic win_end;
  logic [31:0] conv_in;

  assign tick_ok  = sample_tick_in && (pipe_vld_q == 3'b000);
  assign has_data = (state_q != StIdle) && (idx_q < play_len_q);
  // Covers both the last real read and a zero-length window's first tick
  assign win_end  = tick_ok && (state_q != StIdle) &&
                    (({1'b0, idx_q} + 13'd1) >= {1'b0, play_len_q});

  always_comb begin
    state_d      = state_q;
    play_bank_d  = play_bank_q;
    write_bank_d = write_bank_q;
    play_len_d   = play_len_q;
    pend_len_d   = pend_len_q;
    idx_d        = idx_q;
    rd_addr_d    = rd_addr_q;
    underrun_d   = underrun_q;
    dropped_d    = 1'b0;
    st_mid       = state_q;
    wb_mid       = write_bank_q;

    if (tick_ok) begin
      if (has_data) begin
        rd_addr_d = {play_bank_q, idx_q};
        idx_d     = idx_q + 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end

    if (win_end) begin
      if (state_q == StPlayPend) begin
        st_mid      = StPlay;
        play_bank_d = ~play_bank_q;
        wb_mid      = ~write_bank_q;
        play_len_d  = pend_len_q;
        idx_d       = '0;
      end else begin
        st_mid = StIdle;
      end
    end

    state_d      = st_mid;
    write_bank_d = wb_mid;

    // A new window is judged against the state after any end-of-window transition
    if (window_len_valid_in) begin
      unique case (st_mid)
        StIdle: begin
          play_bank_d  = wb_mid;
          write_bank_d = ~wb_mid;
          play_len_d   = clip_len(window_len_in);
          idx_d        = '0;
          state_d      = StPlay;
        end
        StPlay: begin
          pend_len_d = clip_len(window_len_in);
          state_d    = StPlayPend;
        end
        StPlayPend: begin
          dropped_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= StIdle;
      play_bank_q    <= 1'b0;
      write_bank_q   <= 1'b0;
      play_len_q     <= '0;
      pend_len_q     <= '0;
      idx_q          <= '0;
      rd_addr_q      <= '0;
      underrun_q     <= 1'b0;
      dropped_q      <= 1'b0;
      pipe_vld_q     <= '0;
      pipe_rd_q      <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      play_bank_q    <= play_bank_d;
      write_bank_q   <= write_bank_d;
      play_len_q     <= play_len_d;
      pend_len_q     <= pend_len_d;
      idx_q          <= idx_d;
      rd_addr_q      <= rd_addr_d;
      underrun_q     <= underrun_d;
      dropped_q      <= dropped_d;
      pipe_vld_q     <= {pipe_vld_q[1:0], tick_ok};
      pipe_rd_q      <= {pipe_rd_q[1:0], tick_ok && has_data};
      sample_valid_q <= pipe_vld_q[2];
    end
  end

  // Underrun ticks still flow down the pipe, but push a zero into the converter
  assign conv_in = pipe_rd_q[2] ? buf_rd_data_in : 32'h0;

  fx_to_pcm16 u_conv (
    .clk_i    (clk_in),
    .rst_i    (rst_in),
    .en_i     (pipe_vld_q[2]),
    .data_i   (conv_in),
    .sample_o (sample_out)
  );

  assign buf_rd_addr_out  = rd_addr_q;
  assign buf_clr_addr_out = rd_addr_q;
  assign buf_clr_we_out   = pipe_rd_q[2];
  assign write_bank_out   = write_bank_q;
  assign ready_out        = (state_q != StPlayPend);
  assign sample_valid_out = sample_valid_q;
  assign underrun_out     = underrun_q;
  assign dropped_out      = dropped_q;

endmodule

// File: tb/tb_psola_playback.sv
// Randomised and directed bench for psola_playback against a window-queue reference model.
module tb_psola_playback;

  localparam int DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [11:0] wlen;
  logic        wvalid;
  logic [12:0] rd_addr;
  logic [31:0] rd_data;
  logic [12:0] clr_addr;
  logic        clr_we;
  logic        wbank;
  logic        ready;
  logic [15:0] smp;
  logic        smp_vld;
  logic        under;
  logic        dropped;

  always #5 clk = ~clk;

  psola_playback dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .sample_tick_in      (tick),
    .window_len_in       (wlen),
    .window_len_valid_in (wvalid),
    .buf_rd_addr_out     (rd_addr),
    .buf_rd_data_in      (rd_data),
    .buf_clr_addr_out    (clr_addr),
    .buf_clr_we_out      (clr_we),
    .write_bank_out      (wbank),
    .ready_out           (ready),
    .sample_out          (smp),
    .sample_valid_out    (smp_vld),
    .underrun_out        (under),
    .dropped_out         (dropped)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Buffer contents: a word reads as zero if it was cleared after it was last written
  logic [31:0] mem_init [0:8191];
  longint      set_t    [0:8191];
  longint      clr_t    [0:8191];
  longint      mclr_t   [0:8191];

  function automatic logic [31:0] dut_word(input int a);
    return (clr_t[a] > set_t[a]) ? 32'h0 : mem_init[a];
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return (mclr_t[a] > set_t[a]) ? 32'h0 : mem_init[a];
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    mem_init[a] = v;
    set_t[a]    = $time;
  endtask

  // Two-cycle read latency buffer
  logic [31:0] r1, r2;
  always @(posedge clk) begin
    r1 <= dut_word(int'(rd_addr));
    r2 <= r1;
    if (clr_we) clr_t[clr_addr] <= $time;
  end
  assign rd_data = r2;

  function automatic int conv(input logic [31:0] d);
    longint v;
    v = longint'($signed(d)) + 1024;
    v = v >>> 11;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference model: a queue of windows, head playing, at most one waiting behind it
  typedef struct {
    bit bank;
    int len;
    int pos;
  } win_t;

  win_t wq[$];
  bit   m_wb;
  bit   m_under;
  int   last_tick;
  int   cyc = 0;
  bit   exp_rdv  [0:DEPTH-1];
  int   exp_addr [0:DEPTH-1];
  bit   exp_clr  [0:DEPTH-1];
  int   exp_clra [0:DEPTH-1];
  bit   exp_sv   [0:DEPTH-1];
  int   exp_smp  [0:DEPTH-1];
  bit   exp_drop [0:DEPTH-1];
  bit   m_ended;
  int   m_a;
  int   m_l;

  always @(posedge clk) begin
    cyc++;
    exp_drop[cyc] = 1'b0;
    if (rst) begin
      wq.delete();
      m_wb      = 1'b0;
      m_under   = 1'b0;
      last_tick = -100;
      for (int i = 0; i <= 4; i++) begin
        exp_rdv[cyc+i] = 1'b0;
        exp_clr[cyc+i] = 1'b0;
        exp_sv[cyc+i]  = 1'b0;
      end
    end else begin
      if (tick && (cyc - last_tick >= 4)) begin
        last_tick = cyc;
        m_ended   = 1'b0;
        if (wq.size() > 0 && wq[0].pos < wq[0].len) begin
          m_a = int'(wq[0].bank) * 4096 + wq[0].pos;
          exp_rdv[cyc]    = 1'b1;
          exp_addr[cyc]   = m_a;
          exp_clr[cyc+2]  = 1'b1;
          exp_clra[cyc+2] = m_a;
          exp_sv[cyc+3]   = 1'b1;
          exp_smp[cyc+3]  = conv(model_word(m_a));
          mclr_t[m_a]     = $time;
          wq[0].pos++;
          if (wq[0].pos >= wq[0].len) m_ended = 1'b1;
        end else begin
          m_under        = 1'b1;
          exp_sv[cyc+3]  = 1'b1;
          exp_smp[cyc+3] = 0;
          if (wq.size() > 0) m_ended = 1'b1;
        end
        if (m_ended) begin
          void'(wq.pop_front());
          if (wq.size() > 0) m_wb = ~m_wb;
        end
      end
      if (wvalid) begin
        m_l = (int'(wlen) > 2048) ? 2048 : int'(wlen);
        if (wq.size() == 0) begin
          wq.push_back('{m_wb, m_l, 0});
          m_wb = ~m_wb;
        end else if (wq.size() == 1) begin
          wq.push_back('{m_wb, m_l, 0});
        end else begin
          exp_drop[cyc] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("sample_valid", longint'(smp_vld), longint'(exp_sv[cyc]));
      if (exp_sv[cyc]) chk("sample", longint'($signed(smp)), longint'(exp_smp[cyc]));
      chk("clr_we", longint'(clr_we), longint'(exp_clr[cyc]));
      if (exp_clr[cyc]) chk("clr_addr", longint'(clr_addr), longint'(exp_clra[cyc]));
      if (exp_rdv[cyc]) chk("rd_addr", longint'(rd_addr), longint'(exp_addr[cyc]));
      chk("ready", longint'(ready), longint'(wq.size() < 2));
      chk("write_bank", longint'(wbank), longint'(m_wb));
      chk("underrun", longint'(under), longint'(m_under));
      chk("dropped", longint'(dropped), longint'(exp_drop[cyc]));
    end
  end

  int smp_q[$];
  int clra_q[$];
  always @(negedge clk) begin
    if (smp_vld) smp_q.push_back(int'($signed(smp)));
    if (clr_we) clra_q.push_back(int'(clr_addr));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic pulse_valid(input int l);
    @(negedge clk);
    wvalid = 1'b1;
    wlen   = 12'(l);
    @(negedge clk) wvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($signed($urandom_range(0, 2097151)) - 1048576);
      2: return 32'h7fff_fc00 ^ 32'($urandom_range(0, 3));
      default: return 32'($urandom_range(0, 4096));
    endcase
  endfunction

  int ns, nc;
  bit want_v, want_t;

  initial begin
    rst    = 1'b1;
    tick   = 1'b0;
    wvalid = 1'b0;
    wlen   = '0;
    cycles(2);
    rst = 1'b0;
    chk("reset_ready", longint'(ready), 1);
    chk("reset_wbank", longint'(wbank), 0);
    chk("reset_under", longint'(under), 0);

    chk("conv_pin_pos", conv(32'd2048), 1);
    chk("conv_pin_half", conv(32'd1024), 1);
    chk("conv_pin_neg", conv(32'hFFFF_F800), -1);
    chk("conv_pin_sat_hi", conv(32'h7FFF_FFFF), 32767);
    chk("conv_pin_sat_lo", conv(32'h8000_0000), -32768);

    // Single window of four known words
    set_word(0, 32'd2048);
    set_word(1, 32'd4096);
    set_word(2, 32'hFFFF_F800);
    set_word(3, 32'd1024);
    ns = smp_q.size();
    nc = clra_q.size();
    pulse_valid(4);
    repeat (4) begin
      pulse_tick();
      cycles(3);
    end
    cycles(6);
    chk("w4_count", smp_q.size() - ns, 4);
    chk("w4_s0", smp_q[ns+0], 1);
    chk("w4_s1", smp_q[ns+1], 2);
    chk("w4_s2", smp_q[ns+2], -1);
    chk("w4_s3", smp_q[ns+3], 1);
    for (int i = 0; i < 4; i++) begin
      chk("w4_clr_addr", clra_q[nc+i], i);
      chk("w4_zeroed", longint'(dut_word(i)), 0);
    end
    chk("w4_ready", longint'(ready), 1);
    chk("w4_wbank", longint'(wbank), 1);
    chk("w4_under", longint'(under), 0);

    // Saturation, in bank 1
    set_word(4096, 32'h7FFF_FFFF);
    set_word(4097, 32'h8000_0000);
    ns = smp_q.size();
    pulse_valid(2);
    repeat (2) begin
      pulse_tick();
      cycles(3);
    end
    cycles(6);
    chk("sat_hi", smp_q[ns+0], 32767);
    chk("sat_lo", smp_q[ns+1], -32768);
    chk("sat_wbank", longint'(wbank), 0);

    // Pending window and drop
    do_reset();
    for (int i = 0; i < 3; i++) set_word(i, rnd_word());
    for (int i = 0; i < 2; i++) set_word(4096 + i, rnd_word());
    nc = clra_q.size();
    pulse_valid(3);
    cycles(1);
    pulse_valid(2);
    chk("pend_ready", longint'(ready), 0);
    chk("pend_wbank", longint'(wbank), 1);
    pulse_valid(5);
    chk("pend_dropped", longint'(dropped), 1);
    repeat (3) begin
      pulse_tick();
      cycles(3);
    end
    chk("pend_ready_after", longint'(ready), 1);
    chk("pend_wbank_after", longint'(wbank), 0);
    repeat (2) begin
      pulse_tick();
      cycles(3);
    end
    cycles(6);
    chk("pend_addr4", clra_q[nc+3], 4096);
    chk("pend_addr5", clra_q[nc+4], 4097);

    // Closely spaced tick must be ignored
    do_reset();
    for (int i = 0; i < 3; i++) set_word(i, rnd_word());
    pulse_valid(3);
    ns = smp_q.size();
    nc = clra_q.size();
    pulse_tick();
    pulse_tick();
    cycles(8);
    chk("spacing_samples", smp_q.size() - ns, 1);
    chk("spacing_reads", clra_q.size() - nc, 1);

    // Length clip to 2048 then underrun
    do_reset();
    for (int i = 0; i < 2048; i++) set_word(i, rnd_word());
    pulse_valid(2500);
    ns = smp_q.size();
    nc = clra_q.size();
    repeat (2048) begin
      pulse_tick();
      cycles(2);
    end
    cycles(4);
    chk("clip_under_before", longint'(under), 0);
    chk("clip_reads", clra_q.size() - nc, 2048);
    pulse_tick();
    cycles(6);
    chk("clip_samples", smp_q.size() - ns, 2049);
    chk("clip_last", smp_q[smp_q.size()-1], 0);
    chk("clip_under", longint'(under), 1);

    // Randomised traffic
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      want_t = ($urandom_range(0, 2) == 0);
      want_v = ($urandom_range(0, 9) == 0);
      tick   = want_t;
      wvalid = 1'b0;
      if (want_v) begin
        if (wq.size() == 2) begin
          wvalid = 1'b1;
          wlen   = 12'($urandom_range(0, 7));
        end else if (cyc - last_tick >= 3) begin
          for (int i = 0; i < 8; i++) set_word(int'(m_wb) * 4096 + i, rnd_word());
          wvalid = 1'b1;
          wlen   = 12'($urandom_range(0, 7));
        end
      end
    end
    @(negedge clk);
    tick   = 1'b0;
    wvalid = 1'b0;
    cycles(8);

    // Reset in the middle of a window
    do_reset();
    pulse_tick();
    cycles(6);
    for (int i = 0; i < 3; i++) set_word(i, rnd_word());
    pulse_valid(3);
    pulse_tick();
    cycles(3);
    pulse_tick();
    chk("mid_under_set", longint'(under), 1);
    do_reset();
    chk("mid_rd_addr", longint'(rd_addr), 0);
    chk("mid_clr_addr", longint'(clr_addr), 0);
    chk("mid_clr_we", longint'(clr_we), 0);
    chk("mid_wbank", longint'(wbank), 0);
    chk("mid_ready", longint'(ready), 1);
    chk("mid_sample", longint'(smp), 0);
    chk("mid_sample_valid", longint'(smp_vld), 0);
    chk("mid_under", longint'(under), 0);
    chk("mid_dropped", longint'(dropped), 0);
    cycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
